// File: rtl/sqrt_sched_pkg.sv
// Shared types and helpers for the square-root scheduler.
// Round-robin pick over up to eight requesters.
package sqrt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    RESP
  } state_t;

  localparam int WORD_LENGTH_DEF = 16;
  localparam int ROOT_W = WORD_LENGTH_DEF / 2;
  localparam int REM_W = ROOT_W + 2;
  localparam int MAX_REQ = 8;

  // Unused upper valid bits are zero, so a mod-8 scan
  // visits live requesters in mod-NUM_REQ order.
  function automatic logic [2:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [2:0] ptr
  );
    logic [2:0] idx;
    logic [2:0] pick;
    pick = ptr;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (valid[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/sqrt_iter_core.sv
// Restoring digit-by-digit square root, one result bit per cycle.
// Exposes the step outputs so the last step can be captured directly.
module sqrt_iter_core
  import sqrt_sched_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  localparam int RW = WORD_LENGTH / 2,
  localparam int XW = RW + 2,
  localparam int CW = $clog2(RW + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] operand,
  output logic                   done,
  output logic [RW-1:0]          root,
  output logic [XW-1:0]          rem
);

  logic [WORD_LENGTH-1:0] op_q;
  logic [RW-1:0]          root_q;
  logic [RW-1:0]          root_d;
  logic [XW-1:0]          rem_q;
  logic [XW-1:0]          rem_d;
  logic [XW-1:0]          trial;
  logic [XW-1:0]          sub;
  logic [CW-1:0]          cnt_q;
  logic                   ge;

  // One step: bring down two bits, try rem - (4*root + 1).
  always_comb begin
    trial = XW'({rem_q, op_q[WORD_LENGTH-1 -: 2]});
    sub = {root_q, 2'b01};
    ge = trial >= sub;
    rem_d = ge ? trial - sub : trial;
    root_d = {root_q[RW-2:0], ge};
    done = cnt_q == CW'(1);
    root = root_d;
    rem = rem_d;
  end

  // Operand shift register, partial root, remainder, step count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= '0;
      root_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      op_q <= operand;
      root_q <= '0;
      rem_q <= '0;
      cnt_q <= CW'(RW);
    end else if (cnt_q != '0) begin
      op_q <= {op_q[WORD_LENGTH-3:0], 2'b00};
      root_q <= root_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/sqrt_scheduler.sv
// Round-robin front end sharing one iterative sqrt core.
// Owns arbitration, sequencing and the response registers.
module sqrt_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int NUM_REQ = 4,
  parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [WORD_LENGTH-1:0]         result,
  output logic [WORD_LENGTH-1:0]         residue,
  output logic                           busy
);

  localparam int RW = WORD_LENGTH / 2;
  localparam int XW = RW + 2;
  localparam int CW = $clog2(RW + 1);

  state_t                 state_q;
  logic [ID_W-1:0]        rr_ptr_q;
  logic [ID_W-1:0]        id_q;
  logic [ID_W-1:0]        rr_next;
  logic [CW-1:0]          iter_cnt_q;
  logic [WORD_LENGTH-1:0] result_q;
  logic [WORD_LENGTH-1:0] residue_q;
  logic [WORD_LENGTH-1:0] operand;
  logic [2:0]             pick;
  logic                   start;
  logic                   core_done;
  logic [RW-1:0]          core_root;
  logic [XW-1:0]          core_rem;

  // Grant only in IDLE and never while reset is held.
  always_comb begin
    pick = rr_pick(MAX_REQ'(req_valid), 3'(rr_ptr_q));
    start = (state_q == IDLE) && reset && (|req_valid);
    req_ready = '0;
    operand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == 3'(i)) begin
        operand = req_data[i*WORD_LENGTH +: WORD_LENGTH];
        req_ready[i] = start;
      end
    end
    if (id_q == ID_W'(NUM_REQ - 1)) rr_next = '0;
    else rr_next = id_q + ID_W'(1);
  end

  sqrt_iter_core #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .operand(operand),
    .done   (core_done),
    .root   (core_root),
    .rem    (core_rem)
  );

  // Control FSM with pointer, iteration count and response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      id_q <= '0;
      iter_cnt_q <= '0;
      result_q <= '0;
      residue_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            id_q <= ID_W'(pick);
            iter_cnt_q <= CW'(RW);
            state_q <= ITER;
          end
        end
        ITER: begin
          iter_cnt_q <= iter_cnt_q - CW'(1);
          if (iter_cnt_q == CW'(1)) state_q <= RESP;
          if (core_done) begin
            result_q <= WORD_LENGTH'(core_root);
            residue_q <= WORD_LENGTH'(core_rem);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
            rr_ptr_q <= rr_next;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = state_q == RESP;
  assign busy = state_q != IDLE;
  assign rsp_id = id_q;
  assign result = result_q;
  assign residue = residue_q;

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Scoreboard bench for the shared square-root scheduler.
// Expected responses are queued at grant, checked on acceptance.
module tb_sqrt_scheduler;
  import sqrt_sched_pkg::*;

  localparam int W = 2 * ROOT_W;
  localparam int NR = 4;

  typedef struct {
    int id;
    int op;
    int res;
    int rem;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [W-1:0]    result;
  logic [W-1:0]    residue;
  logic            busy;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   hs_edge = 0;
  int   mode = 0;
  int   m_ptr = 0;
  bit   m_busy = 0;
  bit   rsp_v_prev = 0;
  exp_t exp_q[$];
  int   id_log[$];

  sqrt_scheduler #(
    .WORD_LENGTH(W),
    .NUM_REQ(NR)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .result   (result),
    .residue  (residue),
    .busy     (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int isqrt(input int op);
    int r = 0;
    while ((r + 1) * (r + 1) <= op) r++;
    return r;
  endfunction

  // Monitor: grant check against a round-robin model, then response.
  always @(negedge clk) begin
    int   idx;
    int   r;
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      m_busy = 0;
      m_ptr = 0;
      rsp_v_prev = 0;
    end else begin
      if (!m_busy && req_valid != 0) begin
        idx = -1;
        for (int k = NR - 1; k >= 0; k--)
          if (req_valid[(m_ptr + k) % NR]) idx = (m_ptr + k) % NR;
        chk("grant", 32'(req_ready), 32'(1) << idx);
        e.id = idx;
        e.op = int'(req_data[idx*W +: W]);
        e.res = isqrt(e.op);
        e.rem = e.op - e.res * e.res;
        exp_q.push_back(e);
        m_busy = 1;
        hs_edge = cyc + 1;
      end else if (req_valid != 0) begin
        chk("no_grant_busy", 32'(req_ready), 0);
      end
      if (rsp_valid && !rsp_v_prev) chk("latency", cyc - hs_edge, W / 2);
      rsp_v_prev = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          r = int'(result);
          chk("rsp_id", 32'(rsp_id), e.id);
          chk("result", 32'(result), e.res);
          chk("residue", 32'(residue), e.rem);
          chk("bound", 32'(r * r <= e.op && e.op < (r + 1) * (r + 1)), 1);
          id_log.push_back(int'(rsp_id));
          m_ptr = (e.id + 1) % NR;
          m_busy = 0;
        end
      end
    end
  end

  task automatic set_req(input int id, input int op);
    req_valid[id] = 1'b1;
    req_data[id*W +: W] = W'(op);
  endtask

  task automatic step();
    logic [NR-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~hs;
    if (mode == 1) rsp_ready = ($urandom_range(0, 2) != 0);
    else if (mode == 0) rsp_ready = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    mode = 0;
    while ((req_valid != 0 || exp_q.size() != 0) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int r0;
    int n;
    int issued;
    rst_n = 0;
    rsp_ready = 1;
    req_data = '0;
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_residue", 32'(residue), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1;

    set_req(0, 127);
    drain();
    set_req(0, 0);
    drain();
    set_req(1, 1);
    drain();
    set_req(2, 16);
    drain();
    set_req(3, 65535);
    drain();

    id_log.delete();
    set_req(0, 4);
    set_req(1, 9);
    set_req(2, 25);
    set_req(3, 100);
    drain();
    set_req(1, 36);
    drain();
    set_req(0, 49);
    set_req(1, 64);
    set_req(2, 81);
    set_req(3, 144);
    drain();
    chk("order_n", id_log.size(), 9);
    if (id_log.size() == 9) begin
      chk("order0", id_log[0], 0);
      chk("order1", id_log[1], 1);
      chk("order2", id_log[2], 2);
      chk("order3", id_log[3], 3);
      chk("order5", id_log[5], 2);
      chk("order6", id_log[6], 3);
      chk("order7", id_log[7], 0);
      chk("order8", id_log[8], 1);
    end

    mode = 2;
    rsp_ready = 0;
    set_req(0, 200);
    n = 0;
    while (req_valid != 0 && n < 20) begin
      step();
      n++;
    end
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_rsp_seen", 32'(rsp_valid), 1);
    set_req(2, 50);
    r0 = int'(result);
    repeat (5) begin
      @(negedge clk);
      chk("t4_stable", 32'(result), r0);
      chk("t4_hold", 32'(rsp_valid), 1);
      chk("t4_no_ready", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_grant2", 32'(req_ready), 32'b0100);
    drain();

    set_req(1, 99);
    n = 0;
    while (req_valid != 0 && n < 20) begin
      step();
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("t5_busy_pre", 32'(busy), 1);
    rst_n = 0;
    #1;
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_result", 32'(result), 0);
    chk("t5_residue", 32'(residue), 0);
    chk("t5_rsp_id", 32'(rsp_id), 0);
    set_req(0, 1000);
    set_req(3, 2500);
    chk("t5_ready", 32'(req_ready), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("t5_grant0", 32'(req_ready), 32'b0001);
    drain();

    mode = 1;
    issued = 0;
    n = 0;
    while (issued < 1000 && n < 40000) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && issued < 1000 &&
            $urandom_range(0, 3) == 0) begin
          set_req(i, int'($urandom_range(0, 65535)));
          issued++;
        end else if (req_valid[i] && $urandom_range(0, 49) == 0) begin
          req_valid[i] = 1'b0;
          issued--;
        end
      end
      step();
      n++;
    end
    if (n >= 40000) chk("rand_timeout", 0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
